// File: rtl/ring_mem_port.sv
// Ring front end for the memory node: slot pass/nullify, token ownership with a
// bounded resend drain, write-line assembly and local read-request arbitration.

module RingMemFifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          overflow
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_doPush;
    logic          w_doPop;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_doPush = push & ~w_full;
    assign w_doPop  = pop & (r_count != '0);
    assign dout     = r_mem[r_rdPtr];
    assign count    = r_count;
    assign overflow = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
            if (push & w_full) r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what the queue holds.
    always_ff @(posedge clock) begin
        if (w_doPush) r_mem[r_wrPtr] <= din;
    end
endmodule

module ring_mem_port #(
    parameter int          NREQ       = 2,
    parameter int          WORDS      = 4,
    parameter int          MOPQ_AW    = 6,
    parameter int          WDQ_AW     = 10,
    parameter int          WDQ_AFULL  = 512,
    parameter int          RSQ_AW     = 6,
    parameter int          MAX_RESEND = 0,
    parameter logic [5:0]  LOCAL_OP   = 6'b000100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inhibit,
    input  logic [31:0]           RingIn,
    input  logic [3:0]            SlotTypeIn,
    input  logic [3:0]            SourceIn,
    output logic [31:0]           RingOut,
    output logic [3:0]            SlotTypeOut,
    output logic [3:0]            SourceOut,
    input  logic [NREQ-1:0]       reqValid,
    input  logic [NREQ*26-1:0]    reqAddr,
    output logic [NREQ-1:0]       reqAck,
    output logic                  memOpValid,
    output logic [40:0]           memOpOut,
    input  logic                  rdMemOp,
    output logic                  wdqEmpty,
    output logic [WORDS*32-1:0]   wdqOut,
    input  logic                  rdWriteData,
    input  logic                  wrResend,
    input  logic [39:0]           resendIn,
    output logic [2:0]            overflow
);
    localparam logic [3:0] SLOT_NULL  = 4'd7;
    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, DUMP, WAIT_TOKEN} state_t;

    state_t               r_state;
    logic [15:0]          r_sent;
    logic [PW-1:0]        r_ptr;
    logic [CW-1:0]        r_wcnt;
    logic [WORDS*32-1:0]  r_line;
    logic                 r_lineFull;

    logic                 w_ok;
    logic                 w_emit;
    logic                 w_nullify;
    logic                 w_ringAddr;
    logic                 w_grantValid;
    logic [PW-1:0]        w_grantIdx;
    logic [25:0]          w_localAddr;
    logic                 w_localPush;
    logic                 w_mopPush;
    logic [40:0]          w_mopDin;
    logic [MOPQ_AW:0]     w_mopCount;
    logic [WDQ_AW:0]      w_wdqCount;
    logic [RSQ_AW:0]      w_rsqCount;
    logic [39:0]          w_rsqHead;
    logic                 w_mopOvf;
    logic                 w_wdqOvf;
    logic                 w_rsqOvf;

    // First requesting channel at or after r_ptr, wrapping; MSB flags a hit.
    function automatic logic [PW:0] pickGrant(input logic [NREQ-1:0] valid,
                                              input logic [PW-1:0] start);
        logic [PW:0] pick;
        int c;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(start) + k;
            if (c >= NREQ) c = c - NREQ;
            if (valid[PW'(c)]) pick = {1'b1, PW'(c)};
        end
        return pick;
    endfunction

    assign w_ok       = ~inhibit & (32'(w_wdqCount) < WDQ_AFULL);
    assign w_emit     = (r_state == DUMP) && (w_rsqCount != '0) &&
                        ((MAX_RESEND == 0) || (32'(r_sent) < MAX_RESEND));
    assign w_nullify  = (SlotTypeIn == SLOT_TOKEN) || (SourceIn == 4'd0) ||
                        ((SlotTypeIn == SLOT_ADDR) && RingIn[31]);
    assign w_ringAddr = (SlotTypeIn == SLOT_ADDR);
    assign {w_grantValid, w_grantIdx} = pickGrant(reqValid, r_ptr);
    assign w_localPush = ~reset & ~w_ringAddr & w_grantValid &
                         (w_mopCount != (MOPQ_AW+1)'(1 << MOPQ_AW));
    assign w_mopPush   = w_ringAddr | w_localPush;
    assign w_mopDin    = w_ringAddr ? {1'b0, SourceIn, SlotTypeIn, RingIn}
                                    : {1'b1, 4'(w_grantIdx), 4'd2, LOCAL_OP, w_localAddr};
    assign memOpValid  = (w_mopCount != '0);
    assign wdqEmpty    = (w_wdqCount == '0);
    assign overflow    = {w_rsqOvf, w_wdqOvf, w_mopOvf};

    always_comb begin
        w_localAddr = '0;
        reqAck      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grantIdx == PW'(i)) w_localAddr = reqAddr[i*26 +: 26];
            reqAck[i] = w_localPush & (w_grantIdx == PW'(i));
        end
    end

    always_comb begin
        RingOut     = RingIn;
        SlotTypeOut = SlotTypeIn;
        SourceOut   = SourceIn;
        if (r_state == DUMP) begin
            if (w_emit) begin
                {SourceOut, SlotTypeOut, RingOut} = w_rsqHead;
            end else begin
                RingOut     = 32'd0;
                SlotTypeOut = SLOT_TOKEN;
                SourceOut   = 4'd0;
            end
        end else if (w_nullify) begin
            RingOut     = 32'd0;
            SlotTypeOut = SLOT_NULL;
            SourceOut   = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_sent  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_ok) r_state <= DUMP;
                DUMP: begin
                    if (w_emit) begin
                        r_sent <= r_sent + 16'd1;
                    end else begin
                        r_sent  <= '0;
                        r_state <= WAIT_TOKEN;
                    end
                end
                WAIT_TOKEN: if (SlotTypeIn == SLOT_TOKEN) r_state <= w_ok ? DUMP : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_localPush) begin
            r_ptr <= (w_grantIdx == PW'(NREQ - 1)) ? '0 : w_grantIdx + PW'(1);
        end
    end

    // The completed line is pushed one cycle after its last word lands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcnt     <= '0;
            r_line     <= '0;
            r_lineFull <= 1'b0;
        end else begin
            r_lineFull <= (SlotTypeIn == SLOT_WDATA) && (r_wcnt == CW'(WORDS - 1));
            if (SlotTypeIn == SLOT_WDATA) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (r_wcnt == CW'(i)) r_line[i*32 +: 32] <= RingIn;
                end
                r_wcnt <= r_wcnt + CW'(1);
            end
        end
    end

    RingMemFifo #(.W(41), .AW(MOPQ_AW)) u_mopq (
        .clock(clock), .reset(reset),
        .push(w_mopPush), .din(w_mopDin),
        .pop(rdMemOp), .dout(memOpOut),
        .count(w_mopCount), .overflow(w_mopOvf)
    );

    RingMemFifo #(.W(WORDS*32), .AW(WDQ_AW)) u_wdq (
        .clock(clock), .reset(reset),
        .push(r_lineFull), .din(r_line),
        .pop(rdWriteData), .dout(wdqOut),
        .count(w_wdqCount), .overflow(w_wdqOvf)
    );

    RingMemFifo #(.W(40), .AW(RSQ_AW)) u_rsq (
        .clock(clock), .reset(reset),
        .push(wrResend), .din(resendIn),
        .pop(w_emit), .dout(w_rsqHead),
        .count(w_rsqCount), .overflow(w_rsqOvf)
    );
endmodule

// File: tb/tb_ring_mem_port.sv
// Directed bench for ring_mem_port: inputs change on the falling edge and
// combinational outputs are sampled 1 time unit later.

module tb_ring_mem_port;
    localparam int NREQ = 3, WORDS = 4, MOPQ_AW = 3, WDQ_AW = 3;
    localparam int WDQ_AFULL = 4, RSQ_AW = 3, MAX_RESEND = 2;
    localparam logic [5:0] LOCAL_OP = 6'b000100;
    localparam logic [3:0] NUL = 4'd7, TOK = 4'd1, ADR = 4'd2, WDT = 4'd3;
    localparam logic [39:0] NULL_SLOT  = {4'd0, 4'd7, 32'd0};
    localparam logic [39:0] TOKEN_SLOT = {4'd0, 4'd1, 32'd0};

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 inhibit = 1'b0;
    logic [31:0]          RingIn = '0;
    logic [3:0]           SlotTypeIn = 4'd7;
    logic [3:0]           SourceIn = '0;
    logic [31:0]          RingOut;
    logic [3:0]           SlotTypeOut;
    logic [3:0]           SourceOut;
    logic [NREQ-1:0]      reqValid = '0;
    logic [NREQ*26-1:0]   reqAddr = '0;
    logic [NREQ-1:0]      reqAck;
    logic                 memOpValid;
    logic [40:0]          memOpOut;
    logic                 rdMemOp = 1'b0;
    logic                 wdqEmpty;
    logic [WORDS*32-1:0]  wdqOut;
    logic                 rdWriteData = 1'b0;
    logic                 wrResend = 1'b0;
    logic [39:0]          resendIn = '0;
    logic [2:0]           overflow;

    int total = 0;
    int bad = 0;
    logic [40:0] expMop[$];
    logic [39:0] expRs[$];

    typedef struct {
        logic [3:0]  ty;
        logic [3:0]  src;
        logic [31:0] data;
        logic [39:0] expRing;
        logic        expPush;
    } ringVec_t;

    ringVec_t vecs[6];
    logic [31:0] words[8];
    logic [25:0] chAddr[NREQ];
    logic [2:0]  ackExp[5];
    int          chSeq[5];
    int          n;

    ring_mem_port #(
        .NREQ(NREQ), .WORDS(WORDS), .MOPQ_AW(MOPQ_AW), .WDQ_AW(WDQ_AW),
        .WDQ_AFULL(WDQ_AFULL), .RSQ_AW(RSQ_AW), .MAX_RESEND(MAX_RESEND),
        .LOCAL_OP(LOCAL_OP)
    ) dut (
        .clock(clock), .reset(reset), .inhibit(inhibit),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqAck(reqAck),
        .memOpValid(memOpValid), .memOpOut(memOpOut), .rdMemOp(rdMemOp),
        .wdqEmpty(wdqEmpty), .wdqOut(wdqOut), .rdWriteData(rdWriteData),
        .wrResend(wrResend), .resendIn(resendIn), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [3:0] ty, input logic [3:0] src,
                                 input logic [31:0] data);
        @(negedge clock);
        SlotTypeIn = ty;
        SourceIn   = src;
        RingIn     = data;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRing(input string name, input logic [39:0] exp);
        checkOutput(name, {SourceOut, SlotTypeOut, RingOut}, exp);
    endtask

    // Pops every expected memory-op entry in order, then confirms the queue is empty.
    task automatic drainMop(input string tag);
        int cnt;
        cnt = expMop.size();
        for (int k = 0; k < cnt; k++) begin
            applyStimulus(NUL, 4'd0, 32'd0);
            rdMemOp = 1'b0;
            #1;
            checkOutput({tag, "_valid"}, memOpValid, 1);
            checkOutput({tag, "_entry"}, memOpOut, expMop.pop_front());
            rdMemOp = 1'b1;
        end
        applyStimulus(NUL, 4'd0, 32'd0);
        rdMemOp = 1'b0;
        #1;
        checkOutput({tag, "_empty"}, memOpValid, 0);
    endtask

    initial begin
        vecs[0] = '{NUL, 4'd2, 32'hDEADBEEF, {4'd2, NUL, 32'hDEADBEEF}, 1'b0};
        vecs[1] = '{ADR, 4'd3, 32'h80000ABC, NULL_SLOT, 1'b1};
        vecs[2] = '{ADR, 4'd4, 32'h00001234, {4'd4, ADR, 32'h00001234}, 1'b1};
        vecs[3] = '{4'd5, 4'd0, 32'hCAFEF00D, NULL_SLOT, 1'b0};
        vecs[4] = '{4'd9, 4'hF, 32'h0BADF00D, {4'hF, 4'd9, 32'h0BADF00D}, 1'b0};
        vecs[5] = '{ADR, 4'd0, 32'h00000055, NULL_SLOT, 1'b1};
        words   = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        ackExp  = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b001};
        chSeq   = '{0, 1, 0, 2, 0};
        for (int i = 0; i < NREQ; i++) begin
            chAddr[i] = 26'h0ABC00 + 26'(i);
            reqAddr[i*26 +: 26] = chAddr[i];
        end

        // Reset with requests pending: nothing may be granted or queued.
        reqValid = '1;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_ack", reqAck, 0);
        checkOutput("rst_mopv", memOpValid, 0);
        checkOutput("rst_wdqe", wdqEmpty, 1);
        checkOutput("rst_ovf", overflow, 0);
        checkRing("rst_ring", NULL_SLOT);

        applyStimulus(NUL, 4'd0, 32'd0);
        reset = 1'b0;
        reqValid = '0;
        #1 checkRing("rel_idle", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("first_token", TOKEN_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("wait_null", NULL_SLOT);
        applyStimulus(TOK, 4'd5, 32'h1234);
        #1 checkRing("tok_in_null", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("token_again", TOKEN_SLOT);

        // Pass/nullify table while waiting for the token.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ty, vecs[i].src, vecs[i].data);
            #1 checkRing($sformatf("vec%0d", i), vecs[i].expRing);
            if (vecs[i].expPush) expMop.push_back({1'b0, vecs[i].src, vecs[i].ty, vecs[i].data});
        end
        drainMop("ring_mop");

        // Round-robin with all channels requesting; ring Address wins cycle 2.
        for (int c = 0; c < 5; c++) begin
            if (c == 2) applyStimulus(ADR, 4'd6, 32'h00000777);
            else        applyStimulus(NUL, 4'd0, 32'd0);
            reqValid = '1;
            #1 checkOutput($sformatf("arb_ack%0d", c), reqAck, ackExp[c]);
            if (c == 2) expMop.push_back({1'b0, 4'd6, ADR, 32'h00000777});
            else expMop.push_back({1'b1, 4'(chSeq[c]), 4'd2, LOCAL_OP, chAddr[chSeq[c]]});
        end
        applyStimulus(NUL, 4'd0, 32'd0);
        reqValid = '0;
        #1 checkOutput("arb_off", reqAck, 0);
        drainMop("arb_mop");

        // Five resend entries drained two per token visit.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(NUL, 4'd0, 32'd0);
            wrResend = 1'b1;
            resendIn = {4'(k + 1), 4'(8 + k), 32'hA0000000 + 32'(k)};
            expRs.push_back(resendIn);
        end
        applyStimulus(NUL, 4'd0, 32'd0);
        wrResend = 1'b0;
        for (int v = 0; v < 3; v++) begin
            n = (expRs.size() > MAX_RESEND) ? MAX_RESEND : expRs.size();
            applyStimulus(TOK, 4'd5, 32'd0);
            #1 checkRing($sformatf("rs%0d_tokin", v), NULL_SLOT);
            for (int j = 0; j < n; j++) begin
                applyStimulus(NUL, 4'd0, 32'd0);
                #1 checkRing($sformatf("rs%0d_entry%0d", v, j), expRs.pop_front());
            end
            applyStimulus(NUL, 4'd0, 32'd0);
            #1 checkRing($sformatf("rs%0d_token", v), TOKEN_SLOT);
            applyStimulus(NUL, 4'd0, 32'd0);
            #1 checkRing($sformatf("rs%0d_after", v), NULL_SLOT);
        end

        // Two back-to-back lines through the write assembler.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(WDT, 4'd2, words[k]);
            #1;
            if (k == 0) checkRing("wd_pass", {4'd2, WDT, 32'h11});
            if (k == 4) checkOutput("wd_latency", wdqEmpty, 1);
            if (k == 5) begin
                checkOutput("wd_line1_avail", wdqEmpty, 0);
                checkOutput("wd_line1", wdqOut, 128'h00000044_00000033_00000022_00000011);
            end
        end
        applyStimulus(NUL, 4'd0, 32'd0);
        applyStimulus(NUL, 4'd0, 32'd0);
        rdWriteData = 1'b1;
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkOutput("wd_line2", wdqOut, 128'h00000088_00000077_00000066_00000055);
        applyStimulus(NUL, 4'd0, 32'd0);
        rdWriteData = 1'b0;
        #1 checkOutput("wd_drained", wdqEmpty, 1);

        // Four lines reach the almost-full mark: the token is withheld.
        for (int k = 0; k < 16; k++) applyStimulus(WDT, 4'd2, 32'h100 + 32'(k));
        applyStimulus(NUL, 4'd0, 32'd0);
        applyStimulus(NUL, 4'd0, 32'd0);
        applyStimulus(TOK, 4'd5, 32'd0);
        #1 checkRing("afull_tokin", NULL_SLOT);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(NUL, 4'd0, 32'd0);
            #1 checkRing($sformatf("afull_park%0d", k), NULL_SLOT);
        end
        applyStimulus(NUL, 4'd0, 32'd0);
        rdWriteData = 1'b1;
        #1 checkRing("afull_popcyc", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        rdWriteData = 1'b0;
        #1 checkRing("afull_pop1", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("afull_resume", TOKEN_SLOT);

        // Three lines queued; six more overflow the eight-deep queue by one.
        for (int k = 0; k < 24; k++) applyStimulus(WDT, 4'd2, 32'h200 + 32'(k));
        applyStimulus(NUL, 4'd0, 32'd0);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkOutput("wdq_overflow", overflow, 3'b010);

        // Reset mid-operation flushes everything and restarts the token.
        applyStimulus(NUL, 4'd0, 32'd0);
        reset = 1'b1;
        applyStimulus(NUL, 4'd0, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst2_ovf", overflow, 0);
        checkOutput("rst2_wdqe", wdqEmpty, 1);
        checkRing("rst2_idle", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("rst2_token", TOKEN_SLOT);

        // Inhibit parks the node in IDLE until it drops.
        inhibit = 1'b1;
        applyStimulus(TOK, 4'd5, 32'd0);
        #1 checkRing("inh_tokin", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("inh_park", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        inhibit = 1'b0;
        #1 checkRing("inh_release", NULL_SLOT);
        applyStimulus(NUL, 4'd0, 32'd0);
        #1 checkRing("inh_token", TOKEN_SLOT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
